// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: opcode/handshake inputs and control/debug outputs between
// the multicycle controller (master) and the shared datapath (slave)
interface mips_multicycle_ctrl_if;
  logic [5:0]  op;
  logic        mem_ready;
  logic        IorD;
  logic        IRWrite;
  logic        PCWrite;
  logic        Branch;
  logic [1:0]  PCSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        ext_sel;
  logic [1:0]  ALUOp;
  logic        RegDst;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemWrite;
  logic [3:0]  state;
  logic        instr_done;
  logic        illegal_op;
  logic [31:0] instr_count;
  modport master (
    input  op, mem_ready,
    output IorD, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB, ext_sel, ALUOp,
           RegDst, MemtoReg, RegWrite, MemWrite, state, instr_done, illegal_op, instr_count
  );
  modport slave (
    output op, mem_ready,
    input  IorD, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB, ext_sel, ALUOp,
           RegDst, MemtoReg, RegWrite, MemWrite, state, instr_done, illegal_op, instr_count
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multicycle MIPS core, with a
// retired-instruction counter and an illegal-opcode pulse for debug
module mips_multicycle_ctrl (
  input  logic clk,
  input  logic rst_n,
  mips_multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    RTYPEEX = 4'd6, ALUWB = 4'd7, BEQ = 4'd8, IMMEX = 4'd9, IMMWB = 4'd10, JUMP = 4'd11
  } state_t;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b, OP_R = 6'h00, OP_BEQ = 6'h04,
                         OP_ADDI = 6'h08, OP_ORI = 6'h0d, OP_J = 6'h02;
  state_t      state_q, state_d;
  logic        instr_done_q, instr_done_d;
  logic        illegal_op_q, illegal_op_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic        retire, is_ori;
  assign is_ori = bus.op == OP_ORI;
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE:  state_d = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                         bus.op == OP_R ? RTYPEEX :
                         bus.op == OP_BEQ ? BEQ :
                         (bus.op == OP_ADDI || is_ori) ? IMMEX :
                         bus.op == OP_J ? JUMP : FETCH;
      MEMADR:  state_d = bus.op == OP_SW ? MEMWR : MEMRD;
      MEMRD:   state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = bus.mem_ready ? FETCH : MEMWR;
      RTYPEEX: state_d = ALUWB;
      IMMEX:   state_d = IMMWB;
      default: state_d = FETCH;
    endcase
    retire = state_d == FETCH && state_q inside {MEMWB, MEMWR, ALUWB, BEQ, IMMWB, JUMP};
    instr_done_d = retire;
    illegal_op_d = state_q == DECODE && state_d == FETCH;
    instr_count_d = instr_count_q + {31'd0, retire};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      instr_done_q  <= 1'b0;
      illegal_op_q  <= 1'b0;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      instr_done_q  <= instr_done_d;
      illegal_op_q  <= illegal_op_d;
      instr_count_q <= instr_count_d;
    end
  end
  // write enables are gated by rst_n so the mem_ready-dependent FETCH terms stay low in reset
  assign bus.IRWrite  = rst_n && state_q == FETCH && bus.mem_ready;
  assign bus.PCWrite  = rst_n && ((state_q == FETCH && bus.mem_ready) || state_q == JUMP);
  assign bus.Branch   = rst_n && state_q == BEQ;
  assign bus.RegWrite = rst_n && state_q inside {MEMWB, ALUWB, IMMWB};
  assign bus.MemWrite = rst_n && state_q == MEMWR;
  assign bus.IorD     = state_q inside {MEMRD, MEMWR};
  assign bus.PCSrc    = state_q == BEQ ? 2'b01 : state_q == JUMP ? 2'b10 : 2'b00;
  assign bus.ALUSrcA  = state_q inside {MEMADR, RTYPEEX, BEQ, IMMEX};
  assign bus.ALUSrcB  = state_q == FETCH ? 2'b01 : state_q == DECODE ? 2'b11 :
                        state_q inside {MEMADR, IMMEX} ? 2'b10 : 2'b00;
  assign bus.ext_sel  = state_q inside {IMMEX, IMMWB} && is_ori;
  assign bus.ALUOp    = state_q == RTYPEEX ? 2'b10 : state_q == BEQ ? 2'b01 :
                        (state_q == IMMEX && is_ori) ? 2'b11 : 2'b00;
  assign bus.RegDst   = state_q == ALUWB;
  assign bus.MemtoReg = state_q == MEMWB;
  assign bus.state    = state_q;
  assign bus.instr_done  = instr_done_q;
  assign bus.illegal_op  = illegal_op_q;
  assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed and randomized instruction streams checked against
// a per-opcode state-path model with per-state control tables
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mips_multicycle_ctrl_if bus();
  mips_multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b, OP_R = 6'h00, OP_BEQ = 6'h04,
                         OP_ADDI = 6'h08, OP_ORI = 6'h0d, OP_J = 6'h02;
  int n_checks = 0;
  int n_pass = 0;
  int mw_cycles = 0;
  logic [31:0] exp_count = 0;
  logic [5:0] cur_op = 0;
  bit pend_done = 0;
  bit pend_ill = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // {IorD,IRWrite,PCWrite,Branch,PCSrc,ALUSrcA,ALUSrcB,ext_sel,ALUOp,RegDst,MemtoReg,RegWrite,MemWrite}
  function automatic logic [15:0] exp_ctrl(input int s, input logic [5:0] o, input logic mr);
    logic iord = 0, irw = 0, pcw = 0, br = 0, srca = 0, ext = 0, rdst = 0, m2r = 0, rw = 0, mw = 0;
    logic [1:0] pcsrc = 0, srcb = 0, aluop = 0;
    case (s)
      0: begin srcb = 2'b01; irw = mr; pcw = mr; end
      1: srcb = 2'b11;
      2: begin srca = 1; srcb = 2'b10; end
      3: iord = 1;
      4: begin m2r = 1; rw = 1; end
      5: begin iord = 1; mw = 1; end
      6: begin srca = 1; aluop = 2'b10; end
      7: begin rdst = 1; rw = 1; end
      8: begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; br = 1; end
      9: begin srca = 1; srcb = 2'b10; ext = o == OP_ORI; aluop = o == OP_ORI ? 2'b11 : 2'b00; end
      10: begin rw = 1; ext = o == OP_ORI; end
      11: begin pcsrc = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {iord, irw, pcw, br, pcsrc, srca, srcb, ext, aluop, rdst, m2r, rw, mw};
  endfunction
  task automatic step(input int s, input logic mr);
    logic [15:0] got;
    bus.mem_ready = mr;
    @(negedge clk);
    got = {bus.IorD, bus.IRWrite, bus.PCWrite, bus.Branch, bus.PCSrc, bus.ALUSrcA, bus.ALUSrcB,
           bus.ext_sel, bus.ALUOp, bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.MemWrite};
    check("state", 32'(bus.state), s);
    check($sformatf("ctrl_s%0d_op%0h", s, cur_op), 32'(got), 32'(exp_ctrl(s, cur_op, mr)));
    check("instr_done", 32'(bus.instr_done), 32'(pend_done));
    check("illegal_op", 32'(bus.illegal_op), 32'(pend_ill));
    check("instr_count", bus.instr_count, exp_count);
    mw_cycles += int'(bus.MemWrite);
    pend_done = 0;
    pend_ill = 0;
    @(posedge clk);
    #1;
  endtask
  // fw: wait cycles in FETCH, mw: wait cycles in MEMRD/MEMWR
  task automatic run_instr(input logic [5:0] o, input int fw, input int mw);
    int plan[$];
    int cyc = 0;
    int exp_cyc;
    bit legal, has_mem;
    cur_op = o;
    bus.op = o;
    case (o)
      OP_LW:   plan = '{0, 1, 2, 3, 4};
      OP_SW:   plan = '{0, 1, 2, 5};
      OP_R:    plan = '{0, 1, 6, 7};
      OP_BEQ:  plan = '{0, 1, 8};
      OP_ADDI: plan = '{0, 1, 9, 10};
      OP_ORI:  plan = '{0, 1, 9, 10};
      OP_J:    plan = '{0, 1, 11};
      default: plan = '{0, 1};
    endcase
    legal = plan.size() > 2;
    has_mem = o == OP_LW || o == OP_SW;
    exp_cyc = plan.size() + fw + (has_mem ? mw : 0);
    foreach (plan[i]) begin
      int s;
      int w;
      bit waits;
      s = plan[i];
      waits = s == 0 || s == 3 || s == 5;
      w = s == 0 ? fw : waits ? mw : 0;
      for (int k = 0; k <= w; k++) begin
        step(s, waits ? logic'(k == w) : logic'($urandom_range(0, 1)));
        cyc++;
      end
    end
    check($sformatf("cycles_op%0h", o), cyc, exp_cyc);
    pend_done = legal;
    pend_ill = !legal;
    if (legal) exp_count++;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [5:0] ops [7];
    ops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_ORI, OP_J};
    bus.op = OP_R;
    bus.mem_ready = 1'b1;
    #12;
    check("rst_state", 32'(bus.state), 0);
    check("rst_IRWrite", 32'(bus.IRWrite), 0);
    check("rst_PCWrite", 32'(bus.PCWrite), 0);
    check("rst_wen", 32'({bus.RegWrite, bus.MemWrite, bus.Branch}), 0);
    check("rst_ALUSrcB", 32'(bus.ALUSrcB), 1);
    check("rst_count", bus.instr_count, 0);
    check("rst_pulses", 32'({bus.instr_done, bus.illegal_op}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(OP_LW, 0, 0);
    mw_cycles = 0;
    run_instr(OP_SW, 0, 3);
    check("sw_memwrite_cycles", mw_cycles, 4);
    run_instr(OP_ADDI, 0, 0);
    run_instr(OP_ORI, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_R, 1, 0);
    run_instr(6'h3f, 0, 0);
    run_instr(OP_LW, 2, 2);
    for (int n = 0; n < 80; n++) begin
      logic [5:0] o;
      int r;
      r = $urandom_range(0, 7);
      if (r < 7) o = ops[r];
      else begin
        o = 6'($urandom);
        while (o inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_ORI, OP_J}) o = 6'($urandom);
      end
      run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    exp_count = 32'hFFFF_FFFF;
    run_instr(OP_J, 0, 0);
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 0);
    cur_op = OP_SW;
    bus.op = OP_SW;
    step(0, 1);
    step(1, 1);
    step(2, 1);
    bus.mem_ready = 1'b1;
    #2;
    check("memwr_before_rst", 32'(bus.MemWrite), 1);
    rst_n = 1'b0;
    #1;
    check("memwr_rst_MemWrite", 32'(bus.MemWrite), 0);
    check("memwr_rst_state", 32'(bus.state), 0);
    check("memwr_rst_count", bus.instr_count, 0);
    check("memwr_rst_IRWrite", 32'(bus.IRWrite), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_count = 0;
    pend_done = 0;
    pend_ill = 0;
    run_instr(OP_ADDI, 1, 0);
    run_instr(OP_BEQ, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS core. It sequences the shared datapath through fetch, decode, execute, memory and writeback steps. Each step drives the ALU operand selects, which include the SrcB source select and the immediate extension mode, plus the register-file, memory, IR and PC enables. Each memory access stalls on a ready handshake. An instruction retire counter is kept for debug.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  opcode from instruction register; stable from DECODE until next IRWrite
- mem_ready  in  1  memory completes the current access this cycle
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- IRWrite  out  1  load instruction register
- PCWrite  out  1  unconditional PC load
- Branch  out  1  PC load qualified by ALU zero
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUSrcA  out  1  0 PC, 1 RD1
- ALUSrcB  out  2  00 RD2, 01 constant 4, 10 extended imm, 11 extended imm<<2
- ext_sel  out  1  immediate extension: 0 sign, 1 zero
- ALUOp  out  2  00 add, 01 sub, 10 use funct, 11 or
- RegDst  out  1  0 rt, 1 rd
- MemtoReg  out  1  0 ALUOut, 1 memory data
- RegWrite  out  1  register-file write enable
- MemWrite  out  1  memory write enable
- state  out  4  current state encoding (debug)
- instr_done  out  1  one-cycle pulse, instruction retired
- illegal_op  out  1  one-cycle pulse, unsupported opcode decoded
- instr_count  out  32  retired-instruction counter, wraps 0xFFFFFFFF->0

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, ALUWB 7, BEQ 8, IMMEX 9, IMMWB 10, JUMP 11. Codes 12-15 go to FETCH next cycle with no outputs asserted.
- Outputs not listed for a state are 0.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - Holds until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00, ext_sel=0 (branch target precompute). Next state by op:
  - 100011 lw, 101011 sw -> MEMADR
  - 000000 R-type -> RTYPEEX
  - 000100 beq -> BEQ
  - 001000 addi, 001101 ori -> IMMEX
  - 000010 j -> JUMP
  - any other opcode -> FETCH, with illegal_op pulsed
- MEMADR: ALUSrcA=1, ALUSrcB=10, ext_sel=0, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Goes to FETCH.
- MEMWR: IorD=1, MemWrite=1. MemWrite stays high every cycle until mem_ready, then goes to FETCH.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Goes to FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Goes to FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10. Goes to IMMWB.
  - addi: ext_sel=0, ALUOp=00.
  - ori: ext_sel=1, ALUOp=11.
- IMMWB: RegDst=0, MemtoReg=0, RegWrite=1, ext_sel held as in IMMEX. Goes to FETCH.
- JUMP: PCSrc=10, PCWrite=1. Goes to FETCH.
- instr_done and instr_count:
  - instr_done is registered. It pulses the cycle after any transition into FETCH from MEMWB, MEMWR, ALUWB, BEQ, IMMWB or JUMP.
  - instr_count increments on the same edge that sets instr_done.
  - An illegal opcode does not retire and is not counted.

## Timing
- Control outputs are Moore decodes of state, except IRWrite and PCWrite in FETCH, which also depend on mem_ready. The decode is combinational with no added latency.
- Cycles per instruction with zero memory wait (mem_ready tied 1): lw 5, sw 4, R 4, addi/ori 4, beq 3, j 3.
- Each memory wait cycle adds 1 cycle in FETCH, MEMRD or MEMWR.
- Reset values while rst_n=0:
  - state=FETCH, instr_count=0, instr_done=0, illegal_op=0.
  - All write enables (IRWrite, PCWrite, RegWrite, MemWrite, Branch) forced 0, regardless of mem_ready.
  - Other outputs take their FETCH values.
- Reset mid-instruction: state returns to FETCH immediately (asynchronously). No partial writeback completes. The count is cleared.
- First fetch begins on the first rising edge after rst_n deasserts.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

## Test plan
- Reset: assert rst_n=0 in the middle of MEMWR with mem_ready=1 -> MemWrite=0 immediately, state=0, instr_count=0.
- lw, mem_ready=1: states 0,1,2,3,4,0 -> RegWrite=1 with MemtoReg=1 in state 4; instr_done pulses once; count=1.
- sw with mem_ready low for 3 cycles in MEMWR -> MemWrite high for 4 cycles, one retire, total 7 cycles.
- addi then ori: IMMEX shows ext_sel=0/ALUOp=00, then ext_sel=1/ALUOp=11; ALUSrcB=10 in both; count=2.
- beq then j: BEQ shows Branch=1, PCSrc=01, ALUOp=01; JUMP shows PCWrite=1, PCSrc=10; each 3 cycles.
- op=111111: DECODE -> FETCH, illegal_op pulses, count unchanged. Separately, drive the count through 0xFFFFFFFF -> it wraps to 0.
